// File: rtl/ps2_rx_event_fifo.sv
// rtl/ps2_rx_event_fifo.sv - PS/2 keyboard receiver with prefix decoding and a FWFT key-event queue
// Optional build macro: PS2_TYPEMATIC_FILTER_EN (suppresses auto-repeat makes of the held key).

module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    input  logic                   clr_err,
    output logic                   valid,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop_ok;
    logic          push_ok;

    assign full    = (count == FULL_CNT);
    assign valid   = (count != '0);
    assign pop_ok  = pop & valid;
    // A full queue still takes a push when the head leaves in the same cycle
    assign push_ok = push & (~full | pop_ok);
    assign head    = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && full && !pop_ok) overflow <= 1'b1;
            else if (clr_err)            overflow <= 1'b0;
        end
    end
endmodule

module ps2_rx_event_fifo #(
    parameter int CLK_HZ     = 100000000,
    parameter int FILT_LEN   = 8,
    parameter int TIMEOUT_US = 2000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2ck,
    input  logic                        ps2d,
    input  logic                        ev_ready,
    input  logic                        clr_err,
    output logic                        ev_valid,
    output logic [7:0]                  ev_code,
    output logic                        ev_break,
    output logic                        ev_ext,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic                        par_err,
    output logic                        frm_err
);
    localparam int TO_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int TW     = $clog2(TO_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

    logic          ck_s1, ck_s2, d_s1, d_s2;
    logic          ck_filt;
    logic [7:0]    flt_cnt;
    logic          fall;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_ok;
    logic [TW-1:0] to_cnt;
    logic          brk, ext;
    logic          byte_ok;
    logic          is_prefix;
    logic          push;
    logic [9:0]    push_data;
    logic [9:0]    head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ck_s1 <= 1'b1;
            ck_s2 <= 1'b1;
            d_s1  <= 1'b1;
            d_s2  <= 1'b1;
        end else begin
            ck_s1 <= ps2ck;
            ck_s2 <= ck_s1;
            d_s1  <= ps2d;
            d_s2  <= d_s1;
        end
    end

    // Level changes only after FILT_LEN consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ck_filt <= 1'b1;
            flt_cnt <= '0;
            fall    <= 1'b0;
        end else if (ck_s2 != ck_filt) begin
            if (flt_cnt == 8'(FILT_LEN - 1)) begin
                ck_filt <= ck_s2;
                flt_cnt <= '0;
                fall    <= ck_filt;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
                fall    <= 1'b0;
            end
        end else begin
            flt_cnt <= '0;
            fall    <= 1'b0;
        end
    end

    assign byte_ok   = (state == STOP) && fall && d_s2 && par_ok;
    assign is_prefix = (shreg == 8'hF0) || (shreg == 8'hE0);
    assign push_data = {ext, brk, shreg};

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [8:0] held;
    logic       held_v;
    logic       held_match;

    assign held_match = held_v && (held == {ext, shreg});
    assign push       = byte_ok && !is_prefix && !(!brk && held_match);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held   <= '0;
            held_v <= 1'b0;
        end else if (byte_ok && !is_prefix) begin
            if (!brk && !held_match) begin
                held   <= {ext, shreg};
                held_v <= 1'b1;
            end else if (brk && held_match) begin
                held_v <= 1'b0;
            end
        end
    end
`else
    assign push = byte_ok && !is_prefix;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_ok  <= 1'b0;
            to_cnt  <= '0;
            brk     <= 1'b0;
            ext     <= 1'b0;
            par_err <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            par_err <= 1'b0;
            frm_err <= 1'b0;
            if (state == IDLE || fall) to_cnt <= '0;
            else                       to_cnt <= to_cnt + 1'b1;

            if (state != IDLE && !fall && to_cnt == TW'(TO_CYC - 1)) begin
                state   <= IDLE;
                frm_err <= 1'b1;
                brk     <= 1'b0;
                ext     <= 1'b0;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!d_s2) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            frm_err <= 1'b1;
                            brk     <= 1'b0;
                            ext     <= 1'b0;
                        end
                    end
                    DATA: begin
                        shreg   <= {d_s2, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PAR;
                    end
                    PAR: begin
                        par_ok <= (^shreg) ^ d_s2;
                        state  <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!d_s2) begin
                            frm_err <= 1'b1;
                            brk     <= 1'b0;
                            ext     <= 1'b0;
                        end else if (!par_ok) begin
                            par_err <= 1'b1;
                            brk     <= 1'b0;
                            ext     <= 1'b0;
                        end else if (shreg == 8'hF0) begin
                            brk <= 1'b1;
                        end else if (shreg == 8'hE0) begin
                            ext <= 1'b1;
                        end else begin
                            brk <= 1'b0;
                            ext <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    ps2_event_fifo #(
        .DEPTH(FIFO_DEPTH),
        .W    (10)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wdata   (push_data),
        .pop     (ev_ready),
        .clr_err (clr_err),
        .valid   (ev_valid),
        .head    (head),
        .count   (fifo_count),
        .overflow(overflow)
    );

    assign ev_ext   = head[9];
    assign ev_break = head[8];
    assign ev_code  = head[7:0];
endmodule
